fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage directly upstream of the decode/execute pair. It holds the program counter and issues word requests to instruction memory over a valid/ready request channel with variable-latency responses. Returned words are buffered in a small FIFO, and each instruction is presented to decode together with its PC. On a taken branch or jump from execute, it flushes the buffer, discards in-flight responses and redirects.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- BUF_DEPTH, 2, instruction buffer entries; power of two, ≥2; also the cap on buffered + outstanding requests
- NOP_WORD, 32'h0000_0013, value driven on instruction when invalid (addi x0,x0,0)

Ports. Reset is synchronous, active-low.
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- imem_req  out  1  request valid
- imem_addr  out  32  request word address (PC)
- imem_ready  in  1  request accepted when imem_req && imem_ready at clk edge
- imem_rvalid  in  1  response valid, in request order, ≥1 cycle after acceptance
- imem_rdata  in  32  response word
- stall  in  1  hazard unit holds decode; head not consumed
- pc_src  in  1  redirect from execute (taken branch/jump)
- jalr_flag  in  1  redirect is JALR
- branch_target  in  32  target when !jalr_flag
- jalr_target  in  32  target when jalr_flag; bit 0 cleared before use
- instruction  out  32  buffer head, NOP_WORD when !instr_valid
- pc_out  out  32  PC of the buffer head
- instr_valid  out  1  head holds a valid instruction
- fetch_misaligned  out  1  sticky misaligned-target flag (FETCH_MISALIGN_TRAP_EN only; tied 0 otherwise)

## Operation
- State: fetch_pc, FIFO (instr, pc) with head/tail pointers and count, outstanding counter, discard counter.
- Issue: imem_req = reset_n && !halted && (count + outstanding − discard) < BUF_DEPTH. imem_addr = fetch_pc.
- On acceptance: fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC→0); outstanding++.
- Response: if discard > 0, drop the word and decrement discard. Otherwise push {imem_rdata, PC of that request} at the tail. A per-request PC queue of BUF_DEPTH entries accompanies each request. Either way, outstanding decrements.
- Pop: instr_valid && !stall at the edge advances head.
- Redirect (pc_src=1): target = jalr_flag ? {jalr_target[31:1],1'b0} : branch_target. Effects:
  - fetch_pc ← target.
  - FIFO cleared.
  - discard ← outstanding after this cycle's accept/response.
  - No pop is counted.
  - A request accepted in the redirect cycle carries the old PC and is added to discard.
- Priority: reset > redirect > response/accept/pop. Redirect overrides stall.
- Simultaneous push and pop with count==BUF_DEPTH cannot occur, because the issue limit prevents overflow. Push and pop in the same cycle leave count unchanged.
- Reset mid-transaction: all counters, the FIFO and fetch_pc reset, and fetch_pc ← RESET_PC. Responses for pre-reset requests are the memory's responsibility; the stage treats post-reset responses as new.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instruction=NOP_WORD, pc_out=0, instr_valid=0, fetch_misaligned=0.
- First imem_req: first cycle with reset_n=1.
- Latency: response at edge N → instr_valid=1 with that word from cycle N+1 (FIFO output, no extra register).
- Redirect at edge R: instr_valid=0 in cycle R+1. The new target is requested in cycle R+1.
- Steady state with 1-cycle memory: one instruction per cycle.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: a redirect target with bits[1:0]≠0 (after JALR bit-0 clear) has these effects:
  - fetch_misaligned is set (sticky until reset or the next aligned redirect).
  - halted=1, so imem_req stays 0.
  - The FIFO is flushed.
  - fetch_pc still takes the target.
- FETCH_MISALIGN_TRAP_EN undefined: the target is force-aligned with bits[1:0]←00, and fetch_misaligned is constant 0.

## Test plan
- Reset, then 1-cycle memory returning PC-as-data, stall=0 → instr_valid from cycle 2; pc_out 0,4,8…; instruction==pc_out each cycle.
- stall=1 for 5 cycles with BUF_DEPTH=2 → at most 2 buffered + 0 outstanding, imem_req=0; head held at same pc_out. On release, sequence continues with no gaps or duplicates.
- Memory latency 3, branch redirect pc_src=1, branch_target=0x100 with 2 requests in flight → both stale responses dropped; first valid instruction has pc_out=0x100.
- JALR redirect, jalr_target=0x0000_0203 → without the macro, fetch at 0x200. With FETCH_MISALIGN_TRAP_EN, fetch_misaligned=1 and no further imem_req until an aligned redirect to 0x300 clears it.
- Redirect in the same cycle as imem_rvalid and stall=1 → the word is discarded, the FIFO is empty next cycle and the target is fetched.
- RESET_PC=0xFFFF_FFF8, run 4 fetches → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4; reset asserted mid-stream → instr_valid=0 and imem_addr=RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, valid/ready imem requests, small instruction FIFO, redirect/flush.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target halts fetch and raises fetch_misaligned.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        pc_src,
    input  logic        jalr_flag,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic        fetch_misaligned
);
    localparam int AW = $clog2(BUF_DEPTH);
    // Stale requests can pile up across back-to-back redirects, so counters get headroom.
    localparam int CW = AW + 4;
    localparam logic [CW-1:0] DEPTH = CW'(BUF_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic [31:0]   pcq       [BUF_DEPTH];
    logic [AW-1:0] head, tail, pcq_head, pcq_tail;
    logic [CW-1:0] count, outstanding, discard, outstanding_nxt;
    logic          halted, accept, drop, push, pop;
    logic [31:0]   target_raw, target;

    assign target_raw = jalr_flag ? {jalr_target[31:1], 1'b0} : branch_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_tgt, misaligned;
    assign target           = target_raw;
    assign misaligned_tgt   = |target_raw[1:0];
    assign halted           = misaligned;
    assign fetch_misaligned = misaligned;

    always_ff @(posedge clk) begin
        if (!reset_n)    misaligned <= 1'b0;
        else if (pc_src) misaligned <= misaligned_tgt;
    end
`else
    assign target           = target_raw & ~32'h3;
    assign halted           = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    assign instr_valid = (count != '0);
    assign instruction = instr_valid ? buf_instr[head] : NOP_WORD;
    assign pc_out      = instr_valid ? buf_pc[head] : 32'h0;
    assign imem_addr   = fetch_pc;
    // Only live requests count against the buffer; doomed ones are excluded.
    assign imem_req    = reset_n && !halted && ((count + outstanding - discard) < DEPTH);

    assign accept          = imem_req && imem_ready;
    assign drop            = (discard != '0);
    assign push            = imem_rvalid && !drop && !pc_src;
    assign pop             = instr_valid && !stall && !pc_src;
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rvalid);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            pcq_head    <= '0;
            pcq_tail    <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (pc_src) begin
            // Everything still in flight, including this cycle's accept, is stale.
            fetch_pc    <= target;
            head        <= '0;
            tail        <= '0;
            pcq_head    <= '0;
            pcq_tail    <= '0;
            count       <= '0;
            outstanding <= outstanding_nxt;
            discard     <= outstanding_nxt;
        end else begin
            outstanding <= outstanding_nxt;
            count       <= count + CW'(push) - CW'(pop);
            if (accept) begin
                fetch_pc       <= fetch_pc + 32'd4;
                pcq[pcq_tail]  <= fetch_pc;
                pcq_tail       <= pcq_tail + 1'b1;
            end
            if (imem_rvalid && drop)
                discard <= discard - 1'b1;
            if (push) begin
                buf_instr[tail] <= imem_rdata;
                buf_pc[tail]    <= pcq[pcq_head];
                tail            <= tail + 1'b1;
                pcq_head        <= pcq_head + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: token-counting reference model plus an in-order memory model.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC  = 32'hFFFF_FFF8;
    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic        stall = 1'b0, pc_src = 1'b0, jalr_flag = 1'b0;
    logic [31:0] branch_target = 32'h0, jalr_target = 32'h0;
    logic [31:0] instruction, pc_out;
    logic        instr_valid, fetch_misaligned;

    fetch_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH), .NOP_WORD(NOP_WORD)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .pc_src(pc_src), .jalr_flag(jalr_flag),
        .branch_target(branch_target), .jalr_target(jalr_target),
        .instruction(instruction), .pc_out(pc_out), .instr_valid(instr_valid),
        .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        mq[$];
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, epoch = 0;
    int          n_acc = 0, n_resp = 0, n_pop = 0;
    logic [31:0] req_pc = RESET_PC, exp_pc = RESET_PC;
    bit          halted_m = 1'b0;
    int          ready_pct = 100, lat_min = 1, lat_max = 1;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        epoch++;
        n_acc = 0; n_resp = 0; n_pop = 0;
        req_pc = RESET_PC; exp_pc = RESET_PC; halted_m = 1'b0;
    endtask

    // One clock: drive at negedge, check outputs, then advance the model at the edge.
    task automatic step(input bit rst, input bit stl, input bit rd, input bit jf,
                        input logic [31:0] bt, input logic [31:0] jt);
        int          inflight, avail;
        bit          req_s, rv_s, rdy_s;
        logic [31:0] raw, tgt;
        req_t        e;
        @(negedge clk);
        reset_n = rst; stall = stl; pc_src = rd; jalr_flag = jf;
        branch_target = bt; jalr_target = jt;
        imem_ready = ($urandom_range(99) < ready_pct);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        inflight = n_acc - n_pop;
        avail    = n_resp - n_pop;
        req_s    = rst && !halted_m && (inflight < BUF_DEPTH);
        chk("imem_req", {31'b0, imem_req}, {31'b0, req_s});
        chk("imem_addr", imem_addr, req_pc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, avail > 0});
        chk("fetch_misaligned", {31'b0, fetch_misaligned}, {31'b0, halted_m});
        if (avail > 0) begin
            chk("pc_out", pc_out, exp_pc);
            chk("instruction", instruction, word_of(exp_pc));
        end else begin
            chk("instruction_nop", instruction, NOP_WORD);
        end
        rv_s  = imem_rvalid;
        rdy_s = imem_ready;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (rv_s) begin
                e = mq.pop_front();
                if (!rd && e.epoch == epoch) n_resp++;
            end
            if (req_s && rdy_s) begin
                mq.push_back('{addr: req_pc, epoch: epoch, due: cyc + $urandom_range(lat_max, lat_min)});
                if (!rd) n_acc++;
                req_pc = req_pc + 32'd4;
            end
            if (!rd && avail > 0 && !stl) begin
                n_pop++;
                exp_pc = exp_pc + 32'd4;
            end
            if (rd) begin
                raw = jf ? {jt[31:1], 1'b0} : bt;
`ifdef FETCH_MISALIGN_TRAP_EN
                tgt      = raw;
                halted_m = |raw[1:0];
`else
                tgt = {raw[31:2], 2'b00};
`endif
                epoch++;
                n_acc = 0; n_resp = 0; n_pop = 0;
                req_pc = tgt; exp_pc = tgt;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n, input bit stl);
        for (int i = 0; i < n; i++) step(1'b1, stl, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        // Reset with undefined state: no checks until the reset edges have happened.
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_instruction", instruction, NOP_WORD);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_misaligned", {31'b0, fetch_misaligned}, 32'h0);

        // Streaming with 1-cycle memory, PC wraps past 0xFFFF_FFFC.
        run(12, 1'b0);
        // Stall holds head and throttles requests, then resumes.
        run(5, 1'b1);
        run(6, 1'b0);
        // Latency 3 with requests in flight, branch to 0x100.
        lat_min = 3; lat_max = 3;
        run(4, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        run(10, 1'b0);
        // JALR to 0x203, then aligned branch to 0x300.
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0203);
        run(8, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        run(8, 1'b0);
        // Redirect together with a response and stall.
        lat_min = 1; lat_max = 1;
        run(3, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
        run(6, 1'b0);
        // Mid-stream reset.
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run(8, 1'b0);

        // Randomised traffic.
        ready_pct = 75; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 2000; i++) begin
            bit          r, s, d, j;
            logic [31:0] b, t;
            r = ($urandom_range(249) != 0);
            s = ($urandom_range(3) == 0);
            d = ($urandom_range(15) == 0);
            j = $urandom_range(1) == 1;
            b = ($urandom_range(7) == 0) ? ($urandom & 32'h0000_0FFF) : {20'h0, $urandom_range(1023), 2'b00};
            t = ($urandom_range(7) == 0) ? ($urandom & 32'h0000_0FFF) : {20'h0, $urandom_range(1023), 2'b00};
            step(r, s, d, j, b, t);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0800, 32'h0);
        run(10, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
